instr_fetch_unit: RTL and testbench

//  Fetch stage directly upstream of the instruction decoder/control unit in the single-cycle RV32I core.

---
 rtl/instr_fetch_unit_pkg.sv | 17 +
 rtl/instr_fetch_unit_fetch_pc_reg.sv | 35 +++
 rtl/instr_fetch_unit.sv | 125 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instr_fetch_unit_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_VALID,
        S_HALT
    } fetch_state_e;

    // addi x0, x0, 0 -- presented to decode whenever no fetched word is held
    localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam int unsigned DEFAULT_MAX_WAIT     = 255;

endpackage

// File: rtl/instr_fetch_unit_fetch_pc_reg.sv
// Program counter register with next-PC selection and redirect alignment check.
module fetch_pc_reg
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        pc_sel,
    input  logic [31:0] alu_data,
    output logic [31:0] pc,
    output logic [31:0] pc_four,
    output logic        target_misaligned
);

    logic [31:0] next_pc;

    // Sequential PC, redirect target (low bits forced to zero) and alignment flag.
    always_comb begin
        pc_four           = pc + 32'd4;
        target_misaligned = pc_sel && (alu_data[1:0] != 2'b00);
        next_pc           = pc_sel ? {alu_data[31:2], 2'b00} : pc_four;
    end

    // A misaligned redirect never updates the PC; the fetch FSM halts instead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_VECTOR;
        end else if (load && !target_misaligned) begin
            pc <= next_pc;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding imem read at a time, valid/ready hand-off to decode,
// branch/jump redirects, sticky misalignment and memory-timeout errors.
//
// Handshake: o_instr_valid/o_instr form a valid/ready source. While o_instr_valid=1
// o_instr and o_pc stay stable until a cycle with i_instr_ready=1, which is the
// transfer; i_pc_sel/i_alu_data are only looked at in that transfer cycle.
// Memory side: o_imem_req is a one-cycle pulse; the reply is accepted only in S_WAIT.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int unsigned MAX_WAIT     = DEFAULT_MAX_WAIT
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_instr_ready,
    input  logic         i_pc_sel,
    input  logic [31:0]  i_alu_data,
    output logic         o_imem_req,
    output logic [31:0]  o_imem_addr,
    input  logic         i_imem_rvalid,
    input  logic [31:0]  i_imem_rdata,
    output logic [31:0]  o_pc,
    output logic [31:0]  o_pc_four,
    output logic [31:0]  o_instr,
    output logic         o_instr_valid,
    output logic         o_misalign,
    output logic         o_fetch_err,
    output fetch_state_e o_state
);

    localparam logic [7:0] WD_LIMIT = 8'(MAX_WAIT);

    fetch_state_e state, state_next;
    logic [7:0]   watchdog, watchdog_next;
    logic         consume, capture, misalign_set, err_set;
    logic         target_misaligned;

    fetch_pc_reg #(
        .RESET_VECTOR(RESET_VECTOR)
    ) u_pc_reg (
        .clk              (i_clk),
        .rst              (i_reset),
        .load             (consume),
        .pc_sel           (i_pc_sel),
        .alu_data         (i_alu_data),
        .pc               (o_pc),
        .pc_four          (o_pc_four),
        .target_misaligned(target_misaligned)
    );

    // Next-state logic, watchdog update and one-cycle event strobes.
    always_comb begin
        state_next    = state;
        watchdog_next = watchdog;
        consume       = 1'b0;
        capture       = 1'b0;
        misalign_set  = 1'b0;
        err_set       = 1'b0;
        case (state)
            S_IDLE: state_next = S_REQ;
            S_REQ: begin
                state_next    = S_WAIT;
                watchdog_next = '0;
            end
            S_WAIT: begin
                if (i_imem_rvalid) begin
                    capture    = 1'b1;
                    state_next = S_VALID;
                end else begin
                    watchdog_next = watchdog + 8'd1;
                    if (watchdog_next == WD_LIMIT) begin
                        err_set    = 1'b1;
                        state_next = S_HALT;
                    end
                end
            end
            S_VALID: begin
                if (i_instr_ready) begin
                    if (target_misaligned) begin
                        misalign_set = 1'b1;
                        state_next   = S_HALT;
                    end else begin
                        consume    = 1'b1;
                        state_next = S_REQ;
                    end
                end
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    // State, watchdog, captured instruction and sticky error flags.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= S_IDLE;
            watchdog    <= '0;
            o_instr     <= NOP_INSTR;
            o_misalign  <= 1'b0;
            o_fetch_err <= 1'b0;
        end else begin
            state    <= state_next;
            watchdog <= watchdog_next;
            if (capture) begin
                o_instr <= i_imem_rdata;
            end
            if (misalign_set) begin
                o_misalign <= 1'b1;
            end
            if (err_set) begin
                o_fetch_err <= 1'b1;
            end
        end
    end

    // Outputs decoded from the registered state.
    always_comb begin
        o_imem_req    = (state == S_REQ);
        o_instr_valid = (state == S_VALID);
        o_imem_addr   = o_pc;
        o_state       = state;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed steps plus a randomized fetch loop
// checked against a PC/instruction reference model.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    localparam logic [31:0] RV       = 32'h0000_0000;
    localparam int          MAX_WAIT = 255;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         instr_ready = 1'b0;
    logic         pc_sel = 1'b0;
    logic [31:0]  alu_data = '0;
    logic         imem_rvalid = 1'b0;
    logic [31:0]  imem_rdata = '0;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic [31:0]  pc;
    logic [31:0]  pc_four;
    logic [31:0]  instr;
    logic         instr_valid;
    logic         misalign;
    logic         fetch_err;
    fetch_state_e state;

    int          n_checks = 0;
    int          n_fails  = 0;
    int          cyc;
    logic [31:0] exp_pc;
    logic [31:0] exp_q[$];

    instr_fetch_unit #(
        .RESET_VECTOR(RV),
        .MAX_WAIT    (MAX_WAIT)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_instr_ready(instr_ready),
        .i_pc_sel     (pc_sel),
        .i_alu_data   (alu_data),
        .o_imem_req   (imem_req),
        .o_imem_addr  (imem_addr),
        .i_imem_rvalid(imem_rvalid),
        .i_imem_rdata (imem_rdata),
        .o_pc         (pc),
        .o_pc_four    (pc_four),
        .o_instr      (instr),
        .o_instr_valid(instr_valid),
        .o_misalign   (misalign),
        .o_fetch_err  (fetch_err),
        .o_state      (state)
    );

    // Clock and cycle counter (cycle 1 is the first cycle after the first edge past reset release).
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, observed hang expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        instr_ready = 1'b0;
        pc_sel = 1'b0;
        imem_rvalid = 1'b0;
        step();
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, NOP_INSTR);
        chk("rst_pc", pc, RV);
        chk("rst_pc_four", pc_four, RV + 32'd4);
        chk("rst_misalign", {31'b0, misalign}, 32'd0);
        chk("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
        chk("rst_state", {29'b0, state}, {29'b0, S_IDLE});
        rst = 1'b0;
        exp_pc = RV;
        exp_q.delete();
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        while (!imem_req && n < budget) begin
            step();
            n++;
        end
        chk("req_seen", {31'b0, imem_req}, 32'd1);
    endtask

    // Wait for a request, answer it after lat cycles, check the word arrives one cycle later.
    task automatic serve(input int lat, input logic [31:0] data, output int req_at);
        logic [31:0] want;
        wait_req(50);
        req_at = cyc;
        chk("req_addr", imem_addr, exp_pc);
        chk("req_pc_four", pc_four, exp_pc + 32'd4);
        for (int i = 0; i < lat; i++) begin
            step();
            chk("req_one_pulse", {31'b0, imem_req}, 32'd0);
            chk("valid_early", {31'b0, instr_valid}, 32'd0);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        exp_q.push_back(data);
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        chk("valid_latency", {31'b0, instr_valid}, 32'd1);
        chk("valid_cycle", cyc - req_at, lat + 1);
        want = exp_q.pop_front();
        chk("instr", instr, want);
        chk("pc", pc, exp_pc);
    endtask

    // Hold ready low for hold cycles (with stray rvalid pulses), then consume.
    task automatic consume(input int hold, input logic sel, input logic [31:0] tgt);
        logic [31:0] held;
        held = instr;
        for (int i = 0; i < hold; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = ~held;
            end
            step();
            imem_rvalid = 1'b0;
            chk("hold_valid", {31'b0, instr_valid}, 32'd1);
            chk("hold_instr", instr, held);
            chk("hold_pc", pc, exp_pc);
            chk("hold_no_req", {31'b0, imem_req}, 32'd0);
        end
        instr_ready = 1'b1;
        pc_sel      = sel;
        alu_data    = tgt;
        step();
        instr_ready = 1'b0;
        pc_sel      = 1'b0;
        alu_data    = $urandom;
        exp_pc = sel ? {tgt[31:2], 2'b00} : exp_pc + 32'd4;
        chk("consume_valid_drop", {31'b0, instr_valid}, 32'd0);
        chk("consume_next_req", {31'b0, imem_req}, 32'd1);
    endtask

    initial begin
        int r0, r1, r2, r3;
        int lat, hold;
        logic sel;
        logic [31:0] tgt;

        // Reset and first fetch with latency 1.
        do_reset();
        serve(1, 32'h0010_0093, r0);
        chk("first_req_cycle", r0, 32'd1);
        chk("first_pc_four", pc_four, 32'h4);
        consume(0, 1'b0, 32'h0);

        // Three back-to-back fetches at latency 3 with ready held high.
        serve(3, 32'h1111_1111, r1);
        consume(0, 1'b0, $urandom);
        serve(3, 32'h2222_2222, r2);
        consume(0, 1'b0, $urandom);
        serve(3, 32'h3333_3333, r3);
        chk("stream_addr_a", r1, r0 + 3);
        chk("stream_spacing_1", r2 - r1, 32'd5);
        chk("stream_spacing_2", r3 - r2, 32'd5);

        // Redirect to 0x100.
        consume(0, 1'b1, 32'h0000_0100);
        serve(2, 32'hABCD_0001, r0);
        chk("redirect_addr", imem_addr, 32'h0000_0100);

        // Decode stalls for 10 cycles, then the sequential fetch continues.
        consume(10, 1'b0, 32'hDEAD_BEEF);
        serve(1, 32'hABCD_0002, r0);
        chk("after_stall_pc", pc, 32'h0000_0104);
        consume(0, 1'b0, 32'h0);

        // Randomized fetches against the reference model.
        for (int i = 0; i < 20; i++) begin
            lat  = $urandom_range(1, 4);
            hold = $urandom_range(0, 3);
            sel  = ($urandom_range(0, 3) == 0);
            tgt  = $urandom & 32'hFFFF_FFFC;
            serve(lat, $urandom, r0);
            consume(hold, sel, tgt);
        end

        // PC wraps from 0xFFFF_FFFC to 0.
        serve(1, $urandom, r0);
        consume(0, 1'b1, 32'hFFFF_FFFC);
        serve(2, $urandom, r0);
        chk("wrap_pc_four", pc_four, 32'h0000_0000);
        consume(0, 1'b0, 32'h0);
        serve(1, 32'h0000_0013, r0);
        chk("wrap_addr", pc, 32'h0000_0000);

        // Misaligned redirect: halt, PC unchanged, no further requests.
        instr_ready = 1'b1;
        pc_sel      = 1'b1;
        alu_data    = 32'h0000_0102;
        step();
        instr_ready = 1'b0;
        pc_sel      = 1'b0;
        chk("misalign_set", {31'b0, misalign}, 32'd1);
        chk("misalign_valid", {31'b0, instr_valid}, 32'd0);
        chk("misalign_pc", pc, exp_pc);
        chk("misalign_state", {29'b0, state}, {29'b0, S_HALT});
        for (int i = 0; i < 20; i++) begin
            step();
            chk("halt_no_req", {31'b0, imem_req}, 32'd0);
        end
        chk("misalign_sticky", {31'b0, misalign}, 32'd1);

        // Memory never answers: watchdog error after MAX_WAIT cycles in S_WAIT.
        do_reset();
        wait_req(5);
        for (int i = 1; i <= MAX_WAIT; i++) begin
            step();
            chk("wd_err_early", {31'b0, fetch_err}, 32'd0);
        end
        step();
        chk("wd_err_set", {31'b0, fetch_err}, 32'd1);
        chk("wd_valid", {31'b0, instr_valid}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("wd_halt_no_req", {31'b0, imem_req}, 32'd0);
            chk("wd_halt_valid", {31'b0, instr_valid}, 32'd0);
        end
        imem_rvalid = 1'b0;
        chk("wd_halt_instr", instr, NOP_INSTR);

        // Reset asserted mid-wait; stale rvalid after release must be dropped.
        do_reset();
        serve(1, 32'h5555_AAAA, r0);
        consume(0, 1'b0, 32'h0);
        wait_req(5);
        step();
        step();
        rst = 1'b1;
        #1;
        chk("midrst_pc", pc, RV);
        chk("midrst_instr", instr, NOP_INSTR);
        chk("midrst_valid", {31'b0, instr_valid}, 32'd0);
        step();
        rst = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hFEED_FACE;
        step();
        chk("midrst_req", {31'b0, imem_req}, 32'd1);
        chk("midrst_addr", imem_addr, RV);
        chk("midrst_stale_valid", {31'b0, instr_valid}, 32'd0);
        step();
        imem_rvalid = 1'b0;
        chk("midrst_stale_instr", instr, NOP_INSTR);
        chk("midrst_stale_valid2", {31'b0, instr_valid}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0040_0113;
        step();
        imem_rvalid = 1'b0;
        chk("midrst_fetch_valid", {31'b0, instr_valid}, 32'd1);
        chk("midrst_fetch_instr", instr, 32'h0040_0113);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
